// File: rtl/aibcr3_signal_rcv.sv
// aibcr3_signal_rcv: receive side of the AIB buffered signal path.
// Brings the far-end signal into clk, applies a programmable stability filter,
// and reports the qualified level, edge pulses, sticky flags and an edge count.
module aibcr3_signal_rcv #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_W      = 8,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              sig_in,
    input  logic [FILT_W-1:0] filt_cnt,
    input  logic              filt_bypass,
    input  logic              clr,
    output logic              sig_out,
    output logic              rise_pls,
    output logic              fall_pls,
    output logic              rise_seen,
    output logic              fall_seen,
    output logic [7:0]        edge_cnt,
    input  logic              vcc,
    input  logic              vssl
);

    localparam logic [FILT_W-1:0] CNT_ONE = 1;

    logic [SYNC_STAGES-1:0] sync_q,      sync_d;
    logic                   sig_out_q,   sig_out_d;
    logic [FILT_W-1:0]      filt_q,      filt_d;
    logic                   rise_pls_q,  rise_pls_d;
    logic                   fall_pls_q,  fall_pls_d;
    logic                   rise_seen_q, rise_seen_d;
    logic                   fall_seen_q, fall_seen_d;
    logic [7:0]             edge_cnt_q,  edge_cnt_d;

    logic                   sync_lvl;
    logic [FILT_W-1:0]      thr_m1;
    logic                   any_edge;

    // Power pins carry no logic; tie them off so they are visibly consumed.
    logic unused_pwr;
    assign unused_pwr = vcc & vssl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Synchronizer shift and filter threshold (a zero threshold behaves as one).
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        thr_m1 = (filt_cnt == '0) ? '0 : (filt_cnt - CNT_ONE);
    end

    // Stability filter: commit the new level after thr consecutive mismatches.
    // Using >= keeps a lowered threshold from stranding the counter above it.
    always_comb begin
        sig_out_d = sig_out_q;
        filt_d    = filt_q;
        if (filt_bypass) begin
            sig_out_d = sync_lvl;
            filt_d    = '0;
        end else if (sync_lvl == sig_out_q) begin
            filt_d    = '0;
        end else if (filt_q >= thr_m1) begin
            sig_out_d = sync_lvl;
            filt_d    = '0;
        end else begin
            filt_d    = filt_q + CNT_ONE;
        end
    end

    // Edge pulses, sticky flags and saturating edge count; a new edge beats clr.
    always_comb begin
        rise_pls_d  = sig_out_d & ~sig_out_q;
        fall_pls_d  = ~sig_out_d & sig_out_q;
        any_edge    = rise_pls_d | fall_pls_d;
        rise_seen_d = rise_pls_d | (rise_seen_q & ~clr);
        fall_seen_d = fall_pls_d | (fall_seen_q & ~clr);
        edge_cnt_d  = edge_cnt_q;
        if (clr) begin
            edge_cnt_d = any_edge ? 8'd1 : 8'd0;
        end else if (any_edge && (edge_cnt_q != 8'hFF)) begin
            edge_cnt_d = edge_cnt_q + 8'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            sync_q      <= {SYNC_STAGES{RST_VAL}};
            sig_out_q   <= RST_VAL;
            filt_q      <= '0;
            rise_pls_q  <= 1'b0;
            fall_pls_q  <= 1'b0;
            rise_seen_q <= 1'b0;
            fall_seen_q <= 1'b0;
            edge_cnt_q  <= 8'd0;
        end else begin
            sync_q      <= sync_d;
            sig_out_q   <= sig_out_d;
            filt_q      <= filt_d;
            rise_pls_q  <= rise_pls_d;
            fall_pls_q  <= fall_pls_d;
            rise_seen_q <= rise_seen_d;
            fall_seen_q <= fall_seen_d;
            edge_cnt_q  <= edge_cnt_d;
        end
    end

    assign sig_out   = sig_out_q;
    assign rise_pls  = rise_pls_q;
    assign fall_pls  = fall_pls_q;
    assign rise_seen = rise_seen_q;
    assign fall_seen = fall_seen_q;
    assign edge_cnt  = edge_cnt_q;

endmodule

// File: tb/tb_aibcr3_signal_rcv.sv
// Bench for aibcr3_signal_rcv: expected edges are queued when stimulus is
// driven and matched against the edge pulses as they appear.
module tb_aibcr3_signal_rcv;

    logic       clk = 1'b0;
    logic       rstb;
    logic       sig_in;
    logic [7:0] filt_cnt;
    logic       filt_bypass;
    logic       clr;
    logic       sig_out, rise_pls, fall_pls, rise_seen, fall_seen;
    logic [7:0] edge_cnt;

    aibcr3_signal_rcv #(.SYNC_STAGES(2), .FILT_W(8), .RST_VAL(1'b0)) dut (
        .clk(clk), .rstb(rstb), .sig_in(sig_in), .filt_cnt(filt_cnt),
        .filt_bypass(filt_bypass), .clr(clr), .sig_out(sig_out),
        .rise_pls(rise_pls), .fall_pls(fall_pls), .rise_seen(rise_seen),
        .fall_seen(fall_seen), .edge_cnt(edge_cnt), .vcc(1'b1), .vssl(1'b0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit rise;
        int cnt;
        int start;
        int lat;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_cnt = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
    endtask

    // Call right after a negedge: queue the edge this change must produce.
    task automatic drive_edge(input bit v, input int lat);
        exp_t e;
        exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        e.rise  = v;
        e.cnt   = exp_cnt;
        e.start = cyc;
        e.lat   = lat;
        q.push_back(e);
        sig_in = v;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edge monitor: every pulse must match the head of the expected queue.
    bit prev_rise = 0, prev_fall = 0;
    always @(negedge clk) begin
        if (prev_rise) chk("rise_width", rise_pls, 0);
        if (prev_fall) chk("fall_width", fall_pls, 0);
        if (rise_pls || fall_pls) begin
            chk("pls_excl", rise_pls & fall_pls, 0);
            if (q.size() == 0) begin
                chk("unexp_edge", rise_pls | fall_pls, 0);
            end else begin
                exp_t e;
                int   d;
                e = q.pop_front();
                d = cyc - e.start - e.lat;
                chk("edge_dir", rise_pls, e.rise);
                chk("edge_lvl", sig_out, e.rise);
                chk("edge_cnt", edge_cnt, e.cnt);
                chk("edge_lat", (d >= -1 && d <= 1) ? 1 : 0, 1);
            end
        end
        prev_rise = rise_pls;
        prev_fall = fall_pls;
    end

    initial begin
        rstb = 1'b0; sig_in = 1'b0; filt_cnt = 8'd4; filt_bypass = 1'b0; clr = 1'b0;

        // Reset with input toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sig_in = ~sig_in;
        end
        @(negedge clk);
        chk("rst_sig_out", sig_out, 0);
        chk("rst_pls", {30'd0, rise_pls, fall_pls}, 0);
        chk("rst_flags", {30'd0, rise_seen, fall_seen}, 0);
        chk("rst_edge_cnt", edge_cnt, 0);
        sig_in = 1'b0;
        rstb   = 1'b1;
        @(negedge clk);
        chk("rel_no_pls", {30'd0, rise_pls, fall_pls}, 0);
        wait_cyc(4);

        // Clean rise and fall, thr=4: latency 2+4.
        drive_edge(1'b1, 6);
        wait_cyc(10);
        chk("rise_sig_out", sig_out, 1);
        chk("rise_seen", rise_seen, 1);
        chk("rise_edge_cnt", edge_cnt, 1);
        drive_edge(1'b0, 6);
        wait_cyc(10);
        chk("fall_seen", fall_seen, 1);
        chk("fall_edge_cnt", edge_cnt, 2);

        // 3-cycle glitch is rejected.
        sig_in = 1'b1;
        wait_cyc(3);
        sig_in = 1'b0;
        wait_cyc(10);
        chk("glitch_sig_out", sig_out, 0);
        chk("glitch_edge_cnt", edge_cnt, 2);

        // 4-cycle pulse is accepted; its trailing fall is accepted too.
        drive_edge(1'b1, 6);
        wait_cyc(4);
        drive_edge(1'b0, 6);
        wait_cyc(10);
        chk("pulse_edge_cnt", edge_cnt, 4);

        // filt_cnt=0 behaves as 1: latency 2+1.
        filt_cnt = 8'd0;
        drive_edge(1'b1, 3);
        wait_cyc(6);
        drive_edge(1'b0, 3);
        wait_cyc(6);
        chk("thr0_edge_cnt", edge_cnt, 6);
        filt_cnt = 8'd4;

        // Bypass: 1-cycle toggles follow with latency 3.
        filt_bypass = 1'b1;
        wait_cyc(3);
        for (int i = 0; i < 6; i++) begin
            drive_edge(~sig_in, 3);
            @(negedge clk);
        end
        wait_cyc(6);
        chk("byp_edge_cnt", edge_cnt, 12);

        // Saturation.
        for (int i = 0; i < 300; i++) begin
            drive_edge(~sig_in, 3);
            @(negedge clk);
        end
        wait_cyc(6);
        chk("sat_edge_cnt", edge_cnt, 255);

        // clr alone.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_cnt = 0;
        chk("clr_edge_cnt", edge_cnt, 0);
        chk("clr_flags", {30'd0, rise_seen, fall_seen}, 0);
        wait_cyc(2);

        // clr sampled on the same edge that raises rise_pls.
        drive_edge(1'b1, 3);
        wait_cyc(2);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_rise_pls", rise_pls, 1);
        chk("clr_rise_seen", rise_seen, 1);
        chk("clr_rise_cnt", edge_cnt, 1);
        wait_cyc(3);
        drive_edge(1'b0, 3);
        wait_cyc(6);

        // Reset mid-filter, thr=8.
        filt_bypass = 1'b0;
        filt_cnt = 8'd8;
        wait_cyc(2);
        sig_in = 1'b1;
        wait_cyc(7);
        rstb = 1'b0;
        @(negedge clk);
        chk("mid_rst_sig_out", sig_out, 0);
        chk("mid_rst_edge_cnt", edge_cnt, 0);
        exp_cnt = 0;
        @(negedge clk);
        rstb = 1'b1;
        begin
            exp_t e;
            exp_cnt = 1;
            e.rise = 1'b1; e.cnt = 1; e.start = cyc; e.lat = 10;
            q.push_back(e);
        end
        wait_cyc(14);
        chk("mid_rst_rise", sig_out, 1);
        chk("mid_rst_seen", rise_seen, 1);
        chk("mid_rst_cnt", edge_cnt, 1);

        chk("q_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aibcr3_signal_rcv.md
Name: aibcr3_signal_rcv

Overview:
Receive-side companion to the AIB pass-through signal buffer. It takes an asynchronous buffered control or sideband signal into the local clock domain and qualifies it with a programmable stability (glitch) filter. It produces the filtered level, single-cycle edge pulses, sticky edge flags and a saturating transition counter for status/debug. It sits at the far end of the buffered path in the aibcr3 IO/sideband logic.

Parameters:
SYNC_STAGES, 2, synchronizer flop depth; legal values 2 or 3.
FILT_W, 8, width of the filter threshold and filter counter.
RST_VAL, 1'b0, reset level of the synchronizer flops and of sig_out.

Ports:
clk  input  1  receive-domain clock.
rstb  input  1  reset; synchronous, active-low; sampled on rising clk.
sig_in  input  1  asynchronous buffered signal from the far-end buffer.
filt_cnt  input  FILT_W  stability threshold in cycles; 0 is treated as 1; quasi-static.
filt_bypass  input  1  1 = sig_out follows the synchronized input with no filtering.
clr  input  1  single-cycle pulse; clears the sticky flags and edge_cnt.
sig_out  output  1  filtered, synchronized level.
rise_pls  output  1  one-cycle pulse when sig_out goes 0->1.
fall_pls  output  1  one-cycle pulse when sig_out goes 1->0.
rise_seen  output  1  sticky rise flag.
fall_seen  output  1  sticky fall flag.
edge_cnt  output  8  saturating count of sig_out transitions.
vcc  input  1  power pin; no logic function.
vssl  input  1  ground pin; no logic function.

Behaviour:
- Reset (rstb=0 at posedge clk):
  - Sync chain and sig_out load RST_VAL.
  - Filter counter loads 0.
  - rise_pls, fall_pls, rise_seen and fall_seen load 0; edge_cnt loads 0.
  - Reset applied mid-filter discards any partial count.
- Synchronizer: a SYNC_STAGES-deep flop chain. sync_q is the last stage. No logic is placed between stages.
- Filter (filt_bypass=0); let thr = max(filt_cnt,1):
  - If sync_q == sig_out, the counter goes to 0.
  - If sync_q != sig_out and counter < thr-1, the counter increments.
  - If sync_q != sig_out and counter == thr-1, sig_out takes sync_q on that edge and the counter goes to 0.
  - Net effect: the input must differ for thr consecutive cycles. Any single-cycle return to the sig_out level restarts the count.
  - Latency from a clean sig_in change to sig_out change is SYNC_STAGES + thr cycles (±1 cycle of sampling uncertainty).
- Bypass (filt_bypass=1):
  - sig_out takes sync_q every cycle, giving a latency of SYNC_STAGES+1.
  - The counter is held at 0.
  - Toggling filt_bypass clears the counter and never produces a spurious edge by itself.
- Edge pulses are registered from the sig_out update and assert in the same cycle that sig_out shows its new value. They last exactly 1 cycle, and rise_pls/fall_pls never assert together.
- Sticky flags:
  - A flag is set by its pulse and cleared by clr.
  - If clr and a new pulse occur in the same cycle, set wins and the flag is 1.
- edge_cnt:
  - Increments by 1 on each rise_pls or fall_pls and saturates at 255 with no wrap.
  - On clr alone it goes to 0.
  - On clr in the same cycle as an edge it goes to 1.
- Post-reset mismatch: if sig_in differs from RST_VAL at reset release, a normal filtered edge is produced after the latency above. This is intentional, and no special suppression is applied.
- The filter counter never exceeds thr-1, even if filt_cnt is lowered mid-count. In that case the next mismatching cycle with counter >= thr-1 commits the change.

Test Plan:
- Reset: hold rstb=0 for 3 cycles with sig_in toggling -> sig_out=RST_VAL=0, all pulses, flags and edge_cnt 0, and no pulse in the first cycle after release.
- Clean rise: SYNC_STAGES=2, filt_cnt=4; sig_in 0->1 held -> sig_out=1 six cycles later (±1); rise_pls high 1 cycle; rise_seen=1; edge_cnt=1.
- Glitch reject: filt_cnt=4; sig_in high for 3 cycles then low -> sig_out stays 0, no pulse, edge_cnt unchanged. A 4-cycle high pulse is then accepted, and a rise followed by a fall yields edge_cnt=2.
- Bypass: filt_bypass=1; sig_in 1-cycle-wide toggles -> sig_out follows 3 cycles later. Each transition pulses and edge_cnt counts each one.
- Saturation/clr: 300 transitions -> edge_cnt=255. clr alone -> 0 and flags cleared. clr coincident with rise_pls -> edge_cnt=1 and rise_seen=1.
- Reset mid-filter: filt_cnt=8; assert rstb=0 after 5 mismatch cycles -> counter=0 and sig_out=0. After release, the full 8-cycle qualification is required before any edge.
